// File: rtl/sha256_pkg.sv
// SHA-256 padder shared types and constants.
// Holds the FSM state encoding and the word byte-mask helper.
package sha256_pkg;

    typedef enum logic [1:0] {
        FILL,
        PAD,
        EMIT,
        EXTRA
    } state_t;

    localparam int BLOCK_W = 512;
    localparam int WORD_W = 32;
    localparam int LEN_W = 64;
    localparam int NSLOT = 16;
    localparam logic [7:0] PAD_BYTE = 8'h80;

    // Keep the nb high-order bytes, put 0x80 at byte nb, zero below it.
    // nb of 4 or more leaves the word untouched.
    function automatic logic [31:0] pad_word(
        input logic [31:0] data,
        input logic [2:0]  nb
    );
        logic [31:0] w;
        w = data;
        for (int b = 0; b < 4; b++) begin
            if (b > int'(nb))
                w[31-8*b -: 8] = 8'h00;
            else if (b == int'(nb))
                w[31-8*b -: 8] = PAD_BYTE;
        end
        return w;
    endfunction

endpackage

// File: rtl/sha256_block_buffer.sv
// Sixteen-slot block store for the SHA-256 padder.
// Writes land at the pointer; length words go to slots 14/15.
module sha256_block_buffer
    import sha256_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               ptr_inc,
    input  logic               ptr_clr,
    input  logic               wr_en,
    input  logic [WORD_W-1:0]  wr_data,
    input  logic [2:0]         wr_nb,
    input  logic               clr_en,
    input  logic               len_en,
    input  logic [63:0]        len_val,
    output logic [4:0]         wptr,
    output logic [BLOCK_W-1:0] data
);

    logic [WORD_W-1:0] slot [NSLOT];

    // Slot storage: clear-from-pointer, then masked write, then length.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NSLOT; i++)
                slot[i] <= '0;
            wptr <= '0;
        end else begin
            for (int i = 0; i < NSLOT; i++)
                if (clr_en && (5'(i) >= wptr))
                    slot[i] <= '0;
            if (wr_en && !wptr[4])
                slot[wptr[3:0]] <= pad_word(wr_data, wr_nb);
            if (len_en) begin
                slot[14] <= len_val[63:32];
                slot[15] <= len_val[31:0];
            end
            if (ptr_clr)
                wptr <= '0;
            else if (ptr_inc)
                wptr <= wptr + 5'd1;
        end
    end

    for (genvar g = 0; g < NSLOT; g++) begin : g_flat
        assign data[BLOCK_W-1-WORD_W*g -: WORD_W] = slot[g];
    end

endmodule

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: word stream in, padded 512-bit blocks out.
// Appends 0x80, zero fill and the 64-bit bit length.
module sha256_msg_padder #(
    parameter int MAX_BLOCKS = 2,
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [2:0]   in_nbytes,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic [1:0]   blk_idx,
    output logic         blk_last,
    output logic         msg_err
);

    import sha256_pkg::*;

    state_t             state;
    logic [LEN_W-4:0]   bytecnt;
    logic [2:0]         last_nb;
    logic               need_extra;
    logic               pend80;

    logic [4:0]         wptr;
    logic               ptr_inc;
    logic               ptr_clr;
    logic               wr_en;
    logic [31:0]        wr_data;
    logic [2:0]         wr_nb;
    logic               clr_en;
    logic               len_en;

    logic               accept;
    logic [2:0]         nb_eff;
    logic               first_word;
    logic [6:0]         blk_bytes;
    logic               fits;
    logic               idx_over;
    logic [LEN_W-1:0]   bitlen;
    logic [LEN_W-4:0]   add_last;
    logic [LEN_W-4:0]   add_full;

    assign in_ready   = (state == FILL) && !reset;
    assign accept     = in_valid && in_ready;
    assign nb_eff     = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
    assign first_word = (wptr == 5'd0) && (bytecnt == '0);
    assign blk_bytes  = {wptr - 5'd1, 2'b00} + {4'd0, last_nb};
    assign fits       = (blk_bytes <= 7'd55);
    assign idx_over   = int'(blk_idx) >= MAX_BLOCKS;
    assign bitlen     = {bytecnt, 3'b000};
    assign add_last   = {{(LEN_W-6){1'b0}}, nb_eff};
    assign add_full   = {{(LEN_W-6){1'b0}}, 3'd4};

    sha256_block_buffer u_buf (
        .clk     (clk),
        .reset   (reset),
        .ptr_inc (ptr_inc),
        .ptr_clr (ptr_clr),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .wr_nb   (wr_nb),
        .clr_en  (clr_en),
        .len_en  (len_en),
        .len_val (bitlen),
        .wptr    (wptr),
        .data    (blk_data)
    );

    // Buffer commands decoded from the current state.
    always_comb begin
        ptr_inc = 1'b0;
        ptr_clr = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        wr_nb   = 3'd4;
        clr_en  = 1'b0;
        len_en  = 1'b0;
        unique case (state)
            FILL: begin
                if (accept) begin
                    wr_en   = 1'b1;
                    ptr_inc = 1'b1;
                    wr_data = in_data;
                    wr_nb   = in_last ? nb_eff : 3'd4;
                end
            end
            PAD: begin
                clr_en = 1'b1;
                wr_en  = (last_nb == 3'd4);
                wr_nb  = 3'd0;
                len_en = fits;
            end
            EMIT: begin
                ptr_clr = blk_ready;
            end
            EXTRA: begin
                clr_en = 1'b1;
                wr_en  = 1'b1;
                wr_nb  = pend80 ? 3'd0 : 3'd4;
                len_en = 1'b1;
            end
        endcase
    end

    // Message FSM with registered block handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FILL;
            bytecnt    <= '0;
            last_nb    <= '0;
            need_extra <= 1'b0;
            pend80     <= 1'b0;
            blk_valid  <= 1'b0;
            blk_idx    <= '0;
            blk_last   <= 1'b0;
            msg_err    <= 1'b0;
        end else begin
            unique case (state)
                FILL: begin
                    if (accept) begin
                        if (first_word)
                            msg_err <= 1'b0;
                        if (in_last) begin
                            bytecnt <= bytecnt + add_last;
                            last_nb <= nb_eff;
                            state   <= PAD;
                        end else begin
                            bytecnt <= bytecnt + add_full;
                            if (wptr == 5'd15) begin
                                state     <= EMIT;
                                blk_valid <= 1'b1;
                                blk_last  <= 1'b0;
                                if (idx_over)
                                    msg_err <= 1'b1;
                            end
                        end
                    end
                end
                PAD: begin
                    if (fits) begin
                        blk_last   <= 1'b1;
                        need_extra <= 1'b0;
                        pend80     <= 1'b0;
                    end else begin
                        blk_last   <= 1'b0;
                        need_extra <= 1'b1;
                        pend80     <= (last_nb == 3'd4) && wptr[4];
                    end
                    state     <= EMIT;
                    blk_valid <= 1'b1;
                    if (idx_over)
                        msg_err <= 1'b1;
                end
                EMIT: begin
                    if (blk_ready) begin
                        blk_valid <= 1'b0;
                        blk_last  <= 1'b0;
                        if (blk_last) begin
                            state   <= FILL;
                            bytecnt <= '0;
                            blk_idx <= '0;
                        end else begin
                            blk_idx <= (blk_idx == 2'd3) ? 2'd3
                                                         : blk_idx + 2'd1;
                            if (need_extra) begin
                                state      <= EXTRA;
                                need_extra <= 1'b0;
                            end else begin
                                state <= FILL;
                            end
                        end
                    end
                end
                EXTRA: begin
                    state     <= EMIT;
                    blk_valid <= 1'b1;
                    blk_last  <= 1'b1;
                    pend80    <= 1'b0;
                    if (idx_over)
                        msg_err <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: random and directed messages
// checked against a byte-level padding model.
module tb_sha256_msg_padder;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [2:0]   in_nbytes;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic [1:0]   blk_idx;
    logic         blk_last;
    logic         msg_err;

    sha256_msg_padder #(.MAX_BLOCKS(2), .LEN_W(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_nbytes (in_nbytes),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_idx   (blk_idx),
        .blk_last  (blk_last),
        .msg_err   (msg_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    byte unsigned msg_q[$];
    logic [511:0] exp_blks[$];
    logic [511:0] got_blks[$];
    logic [31:0]  wd_q[$];
    logic         wl_q[$];
    logic [2:0]   wn_q[$];
    int           exp_valid_cyc;

    // Reference: FIPS 180-4 padding on a byte list, cut into 64-byte blocks.
    task automatic build_model();
        byte unsigned p[$];
        longint unsigned bl;
        logic [511:0] b;
        p = msg_q;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = longint'(msg_q.size()) * 8;
        for (int j = 7; j >= 0; j--) p.push_back(8'(bl >> (8 * j)));
        exp_blks.delete();
        for (int i = 0; i < p.size() / 64; i++) begin
            b = '0;
            for (int j = 0; j < 64; j++) b[511-8*j -: 8] = p[64*i+j];
            exp_blks.push_back(b);
        end
    endtask

    task automatic build_words(input int zero_tail, input int big_nb);
        int n, nfull, rem, nw;
        logic [31:0] w;
        n = msg_q.size();
        nfull = n / 4;
        rem = n % 4;
        wd_q.delete(); wl_q.delete(); wn_q.delete();
        nw = (rem != 0 || n == 0 || zero_tail != 0) ? nfull + 1 : nfull;
        for (int i = 0; i < nw; i++) begin
            w = $urandom;
            for (int b = 0; b < 4; b++)
                if (4 * i + b < n) w[31-8*b -: 8] = msg_q[4*i+b];
            wd_q.push_back(w);
            wl_q.push_back(i == nw - 1);
            if (i != nw - 1) wn_q.push_back(3'd4);
            else if (4 * i + 4 <= n)
                wn_q.push_back(big_nb != 0 ? 3'($urandom_range(5, 7)) : 3'd4);
            else wn_q.push_back(3'(n - 4 * i));
        end
    endtask

    task automatic drive_words(input int idle);
        int budget;
        int acc;
        for (int k = 0; k < wd_q.size(); k++) begin
            @(negedge clk);
            if (idle != 0 && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data = wd_q[k];
            in_last = wl_q[k];
            in_nbytes = wn_q[k];
            budget = 0;
            while (!in_ready && budget < 3000) begin
                @(negedge clk);
                budget++;
            end
            if (!in_ready) begin
                checks++;
                errors++;
                $display("FAIL in_timeout word %0d in_ready=%b exp=1", k, in_ready);
                in_valid = 1'b0;
                return;
            end
            acc = cyc + 1;
            if (wl_q[k]) exp_valid_cyc = acc + 1;
            else if (k % 16 == 15) exp_valid_cyc = acc;
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic collect(input int stall);
        int budget, s, hs, n, nw;
        logic [511:0] d;
        n = exp_blks.size();
        nw = wd_q.size();
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            budget = 0;
            while (!blk_valid && budget < 3000) begin
                @(negedge clk);
                budget++;
            end
            if (!blk_valid) begin
                checks++;
                errors++;
                $display("FAIL blk_timeout blk%0d blk_valid=%b exp=1", i, blk_valid);
                return;
            end
            if (exp_valid_cyc >= 0) begin
                checks++;
                if (cyc !== exp_valid_cyc) begin
                    errors++;
                    $display("FAIL latency blk%0d got cyc %0d exp %0d", i, cyc, exp_valid_cyc);
                end
            end
            exp_valid_cyc = -1;
            checks++;
            if (blk_data !== exp_blks[i]) begin
                errors++;
                $display("FAIL data blk%0d got %h exp %h", i, blk_data, exp_blks[i]);
            end
            checks++;
            if (blk_idx !== 2'(i > 3 ? 3 : i)) begin
                errors++;
                $display("FAIL idx blk%0d got %0d exp %0d", i, blk_idx, (i > 3 ? 3 : i));
            end
            checks++;
            if (blk_last !== (i == n - 1)) begin
                errors++;
                $display("FAIL last blk%0d got %b exp %b", i, blk_last, (i == n - 1));
            end
            checks++;
            if (msg_err !== (i >= 2)) begin
                errors++;
                $display("FAIL msg_err blk%0d got %b exp %b", i, msg_err, (i >= 2));
            end
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL in_ready_emit blk%0d got %b exp 0", i, in_ready);
            end
            d = blk_data;
            got_blks.push_back(d);
            s = (stall >= 0) ? stall : int'($urandom_range(0, 3));
            repeat (s) begin
                @(negedge clk);
                checks++;
                if (blk_data !== d || blk_valid !== 1'b1 || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall blk%0d valid=%b rdy=%b data %h exp %h",
                             i, blk_valid, in_ready, blk_data, d);
                end
            end
            blk_ready = 1'b1;
            hs = cyc + 1;
            @(negedge clk);
            blk_ready = 1'b0;
            if (i + 1 == n - 1 && nw <= 16 * (i + 1)) exp_valid_cyc = hs + 1;
        end
    endtask

    task automatic run_msg(input int stall, input int zero_tail,
                           input int idle, input int big_nb);
        build_model();
        build_words(zero_tail, big_nb);
        exp_valid_cyc = -1;
        got_blks.delete();
        fork
            drive_words(idle);
            collect(stall);
        join
        checks++;
        if (in_ready !== 1'b1 || blk_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after in_ready=%b blk_valid=%b exp 1/0", in_ready, blk_valid);
        end
    endtask

    task automatic rand_msg(input int n);
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b1;
        in_last = 1'b1;
        in_nbytes = 3'd3;
        in_data = 32'h61626300;
        blk_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({in_ready, blk_valid, blk_idx, blk_last, msg_err} !== 6'd0 || blk_data !== '0) begin
            errors++;
            $display("FAIL reset_vals rdy=%b v=%b idx=%0d last=%b err=%b data %h exp all 0",
                     in_ready, blk_valid, blk_idx, blk_last, msg_err, blk_data);
        end
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %b exp 1", in_ready);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (blk_valid !== 1'b0) begin
            errors++;
            $display("FAIL word_in_reset blk_valid=%b exp 0", blk_valid);
        end
    endtask

    task automatic test_abc();
        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg(0, 0, 0, 0);
        checks++;
        if (got_blks.size() != 1 || got_blks[0][511:480] !== 32'h61626380 ||
            got_blks[0][31:0] !== 32'h18) begin
            errors++;
            $display("FAIL abc_words n=%0d w0=%h w15=%h exp 1/61626380/00000018",
                     got_blks.size(), got_blks.size() ? got_blks[0][511:480] : 32'h0,
                     got_blks.size() ? got_blks[0][31:0] : 32'h0);
        end
    endtask

    task automatic test_empty();
        msg_q.delete();
        run_msg(1, 0, 0, 0);
        checks++;
        if (got_blks.size() != 1 || got_blks[0] !== {32'h80000000, 480'd0}) begin
            errors++;
            $display("FAIL empty n=%0d blk %h exp 80000000 then zeros",
                     got_blks.size(), got_blks.size() ? got_blks[0] : 512'd0);
        end
    endtask

    task automatic test_boundary_55_56();
        rand_msg(55);
        run_msg(0, 0, 0, 0);
        checks++;
        if (got_blks.size() != 1 || got_blks[0][63:0] !== 64'h1B8 ||
            got_blks[0][95:64] !== {msg_q[52], msg_q[53], msg_q[54], 8'h80}) begin
            errors++;
            $display("FAIL len55 n=%0d tail %h exp word13 end 80, len 1b8",
                     got_blks.size(), got_blks.size() ? got_blks[0][95:0] : 96'd0);
        end
        rand_msg(56);
        run_msg(2, 0, 0, 0);
        checks++;
        if (got_blks.size() != 2 || got_blks[0][63:0] !== 64'h80000000_00000000 ||
            got_blks[1] !== 512'h1C0) begin
            errors++;
            $display("FAIL len56 n=%0d b0tail %h b1 %h exp 8000000000000000 / 1c0",
                     got_blks.size(), got_blks.size() ? got_blks[0][63:0] : 64'd0,
                     got_blks.size() > 1 ? got_blks[1] : 512'd0);
        end
    endtask

    task automatic test_stall_64();
        rand_msg(64);
        run_msg(5, 0, 0, 0);
        checks++;
        if (got_blks.size() != 2 || got_blks[1] !== {32'h80000000, 448'd0, 32'h200}) begin
            errors++;
            $display("FAIL len64 n=%0d b1 %h exp 80000000..00000200",
                     got_blks.size(), got_blks.size() > 1 ? got_blks[1] : 512'd0);
        end
        checks++;
        if (msg_err !== 1'b0) begin
            errors++;
            $display("FAIL len64_err got %b exp 0", msg_err);
        end
    endtask

    task automatic test_err_and_reset();
        rand_msg(130);
        run_msg(-1, 0, 1, 0);
        checks++;
        if (msg_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got %b exp 1", msg_err);
        end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (msg_err !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL err_reset err=%b rdy=%b exp 0/0", msg_err, in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data = $urandom;
            in_last = 1'b0;
            in_nbytes = 3'd4;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (blk_valid !== 1'b1 || blk_idx !== 2'd0) begin
            errors++;
            $display("FAIL held_blk valid=%b idx=%0d exp 1/0", blk_valid, blk_idx);
        end
        blk_ready = 1'b1;
        @(negedge clk);
        blk_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data = $urandom;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (blk_idx !== 2'd1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_fill idx=%0d rdy=%b exp 1/1", blk_idx, in_ready);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({in_ready, blk_valid, blk_idx, blk_last, msg_err} !== 6'd0 || blk_data !== '0) begin
            errors++;
            $display("FAIL mid_reset rdy=%b v=%b idx=%0d last=%b err=%b data %h exp all 0",
                     in_ready, blk_valid, blk_idx, blk_last, msg_err, blk_data);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_mid_reset got %b exp 1", in_ready);
        end
        test_abc();
    endtask

    task automatic test_random();
        for (int m = 0; m < 25; m++) begin
            rand_msg(m == 0 ? 260 : int'($urandom_range(0, 200)));
            run_msg(-1, int'($urandom_range(0, 1)), 1, int'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_empty();
        test_boundary_55_56();
        test_stall_64();
        test_err_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
Front end of the SHA-256 datapath. Accepts a raw message as a stream of 32-bit big-endian words and applies FIPS 180-4 §5.1.1 padding: a 0x80 byte, zero fill, and a 64-bit bit-length.
Emits complete 512-bit blocks over a valid/ready handshake, in the word order the message scheduler loads them: word0 in bits [511:480].
Also reports the block index so downstream logic can enforce the two-block scheduler limit.

Parameters:
MAX_BLOCKS, 2, padded blocks per message supported downstream; exceeding it raises msg_err
LEN_W, 64, width of the bit-length field appended to the final block (fixed by the standard)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  message word valid
in_ready  output  1  padder can accept a word
in_data  input  32  message word, big-endian (first byte in [31:24])
in_last  input  1  final word of the message
in_nbytes  input  3  valid bytes in the last word, 0..4; sampled only with in_last; 0 is legal only for the empty message or after 4-byte words
blk_valid  output  1  blk_data holds a complete block
blk_ready  input  1  consumer accepts the block
blk_data  output  512  padded block, word0 in [511:480]
blk_idx  output  2  index of the current block within the message, 0-based, saturates at 3
blk_last  output  1  current block is the final block of the message
msg_err  output  1  sticky; block count exceeded MAX_BLOCKS; cleared by reset or by the next message's first accepted word

Behaviour:
- Reset values: in_ready=0, blk_valid=0, blk_data=0, blk_idx=0, blk_last=0, msg_err=0. All state, word pointer, and byte counter clear. Reset asserted mid-message aborts the message and drops any held block.
- First cycle after reset deasserts: state FILL, in_ready=1.
- States: FILL, PAD, EMIT, EXTRA.
- FILL (in_ready=1):
  - Non-last word accepted: store at slot wptr, wptr++, bytecnt += 4. If wptr was 15, go to EMIT with blk_last=0.
  - Last word accepted: keep the in_nbytes high-order bytes and zero the rest. If in_nbytes<4, write 0x80 at byte offset in_nbytes. bytecnt += in_nbytes. Go to PAD.
- PAD (one cycle):
  - Zero-fill all slots after the last data slot.
  - If in_nbytes was 4, place 0x80 at byte 0 of the next slot when one exists (wptr≤15).
  - Let p = bytecnt mod 64. If p≤55, write bitlen = bytecnt*8 (64-bit) to words 14..15 (word14 holds the upper 32 bits), set blk_last=1, go to EMIT.
  - Otherwise set need_extra (plus pend80 if 0x80 did not fit), blk_last=0, go to EMIT.
- EMIT: blk_valid=1 and blk_data/blk_idx/blk_last held stable until blk_ready.
  - On the handshake: blk_idx++ (saturating).
  - If blk_last: return to FILL, clear wptr, bytecnt, blk_idx.
  - Else if need_extra: go to EXTRA.
  - Else: return to FILL, clear wptr.
  - If an emitted block index ≥ MAX_BLOCKS, set msg_err. The block is still emitted.
- EXTRA (one cycle): build a block of zeros. Word0=0x80000000 if pend80. Words 14..15 = bitlen. blk_last=1. Go to EMIT.
- Latency: last word accepted at cycle t → blk_valid at t+2. Full data block (16th word) accepted at t → blk_valid at t+1. Extra block valid 2 cycles after the prior block's handshake.
- in_ready=0 in PAD, EMIT, and EXTRA. There is no input/output overlap. Sustained throughput is 16 words per 17 cycles plus consumer stalls.
- Length counter: 61-bit byte count, so the bit length is exactly 64 bits. Messages ≥2^61 bytes are out of scope.
- in_nbytes>4 with in_last is treated as 4. Behaviour with in_valid high during reset is defined: the word is ignored.

Decomposition:
- Package sha256_pkg: state enum (FILL, PAD, EMIT, EXTRA), BLOCK_W=512, WORD_W=32, LEN_W=64, PAD_BYTE=8'h80, and a function that byte-masks a word and inserts 0x80 at an offset.
- One natural sub-module: sha256_block_buffer. It is a 16×32 slot register with a write pointer, a masked-write port, and a clear-above-pointer control, keeping the FSM separate from storage.

Test Plan:
1. "abc": in_data=0x61626300, in_last, nbytes=3 → one block: word0=0x61626380, words1..14=0, word15=0x00000018, blk_idx=0, blk_last=1, valid 2 cycles after accept.
2. Empty message: in_last, nbytes=0 → word0=0x80000000, words1..15=0, blk_last=1.
3. 55 bytes (13 words + last nbytes=3) → single block: byte55=0x80, word14=0, word15=0x000001B8.
4. 56 bytes (14 full words, last nbytes=4) → block0: word14=0x80000000, word15=0, blk_last=0. Block1: words0..14=0, word15=0x000001C0, blk_idx=1, blk_last=1.
5. 64 bytes with blk_ready held low 5 cycles on each block → blk_data stable while stalled, in_ready=0 throughout. Block1 word0=0x80000000, word15=0x00000200. msg_err=0.
6. 130-byte message → three blocks, msg_err rises with block index 2. Reset asserted mid-FILL of a second message → all outputs return to reset values immediately; a following "abc" pads correctly.
